gray_stream_checker: RTL and testbench

- Receiving end of the Gray-code counter interface: samples a WIDTH-bit Gray-coded count stream.
- Decodes each sample to binary and checks that consecutive samples are legal single steps: either +1 modulo 2^WIDTH or a hold.
- Reports wrap-arounds (the counter's overflow event) and sequence faults.
- Sits beside any Gray counter in the design as an in-circuit monitor and decoder.

---
 rtl/gray_stream_checker.sv | 129 ++++++++++++
 tb/tb_gray_stream_checker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/gray_stream_checker.sv
// In-circuit monitor for a Gray-coded count stream: decodes each sample to binary,
// checks that successive samples hold or advance by one, and counts wraps and faults.
module gray_stream_checker #(
   parameter int WIDTH      = 3,
   parameter int WRAP_CNT_W = 8,
   parameter int ERR_CNT_W  = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_clear,
   input  logic                  i_valid,
   input  logic [WIDTH-1:0]      i_gray,
   output logic [WIDTH-1:0]      o_binary,
   output logic                  o_bin_valid,
   output logic                  o_wrap,
   output logic [WRAP_CNT_W-1:0] o_wrap_count,
   output logic                  o_step_err,
   output logic                  o_error,
   output logic [ERR_CNT_W-1:0]  o_err_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_TRACK = 2'd1,
      S_FAULT = 2'd2
   } state_t;

   state_t                r_state, w_state_next;
   logic [WIDTH-1:0]      r_ref, w_ref_next;
   logic [WIDTH-1:0]      r_binary, w_binary_next;
   logic                  r_bin_valid, w_bin_valid_next;
   logic                  r_wrap, w_wrap_next;
   logic [WRAP_CNT_W-1:0] r_wrap_cnt, w_wrap_cnt_next;
   logic                  r_step_err, w_step_err_next;
   logic                  r_error, w_error_next;
   logic [ERR_CNT_W-1:0]  r_err_cnt, w_err_cnt_next;

   logic [WIDTH-1:0]      w_dec;
   logic [WIDTH-1:0]      w_ref_inc;

   // Each binary bit is the XOR of all Gray bits at or above it; no ripple chain.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_decode
         assign w_dec[gi] = ^i_gray[WIDTH-1:gi];
      end
   endgenerate

   assign w_ref_inc = r_ref + WIDTH'(1);

   always_comb begin
      w_state_next     = r_state;
      w_ref_next       = r_ref;
      w_binary_next    = r_binary;
      w_bin_valid_next = 1'b0;
      w_wrap_next      = 1'b0;
      w_wrap_cnt_next  = r_wrap_cnt;
      w_step_err_next  = 1'b0;
      w_error_next     = r_error;
      w_err_cnt_next   = r_err_cnt;

      if (i_clear) begin
         w_state_next    = S_IDLE;
         w_wrap_cnt_next = '0;
         w_error_next    = 1'b0;
         w_err_cnt_next  = '0;
      end else if (i_valid) begin
         // Every accepted sample becomes the reference, so checking resyncs after a fault.
         w_ref_next       = w_dec;
         w_binary_next    = w_dec;
         w_bin_valid_next = 1'b1;
         case (r_state)
            S_IDLE: begin
               w_state_next = S_TRACK;
            end
            default: begin
               if (w_dec == r_ref) begin
                  w_state_next = r_state;
               end else if (w_dec == w_ref_inc) begin
                  if (&r_ref) begin
                     w_wrap_next     = 1'b1;
                     w_wrap_cnt_next = r_wrap_cnt + WRAP_CNT_W'(1);
                  end
               end else begin
                  w_step_err_next = 1'b1;
                  w_error_next    = 1'b1;
                  w_state_next    = S_FAULT;
                  if (!(&r_err_cnt)) begin
                     w_err_cnt_next = r_err_cnt + ERR_CNT_W'(1);
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_ref       <= '0;
         r_binary    <= '0;
         r_bin_valid <= 1'b0;
         r_wrap      <= 1'b0;
         r_wrap_cnt  <= '0;
         r_step_err  <= 1'b0;
         r_error     <= 1'b0;
         r_err_cnt   <= '0;
      end else begin
         r_state     <= w_state_next;
         r_ref       <= w_ref_next;
         r_binary    <= w_binary_next;
         r_bin_valid <= w_bin_valid_next;
         r_wrap      <= w_wrap_next;
         r_wrap_cnt  <= w_wrap_cnt_next;
         r_step_err  <= w_step_err_next;
         r_error     <= w_error_next;
         r_err_cnt   <= w_err_cnt_next;
      end
   end

   assign o_binary     = r_binary;
   assign o_bin_valid  = r_bin_valid;
   assign o_wrap       = r_wrap;
   assign o_wrap_count = r_wrap_cnt;
   assign o_step_err   = r_step_err;
   assign o_error      = r_error;
   assign o_err_count  = r_err_cnt;

endmodule

// File: tb/tb_gray_stream_checker.sv
// Bench for gray_stream_checker: directed scenarios, a long wrap run and randomized
// streams, all compared against an arithmetic model of the stepping rules.
module tb_gray_stream_checker;

   localparam int W   = 3;
   localparam int WCW = 8;
   localparam int ECW = 4;
   localparam int N   = 1 << W;

   logic           clk = 1'b0;
   logic           rst;
   logic           clr;
   logic           vld;
   logic [W-1:0]   gray;
   logic [W-1:0]   binary;
   logic           bin_valid;
   logic           wrap;
   logic [WCW-1:0] wrap_count;
   logic           step_err;
   logic           error;
   logic [ECW-1:0] err_count;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int m_have, m_ref, m_bin, m_bv, m_wrap, m_wc, m_se, m_err, m_ec;

   gray_stream_checker #(.WIDTH(W), .WRAP_CNT_W(WCW), .ERR_CNT_W(ECW)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_clear      (clr),
      .i_valid      (vld),
      .i_gray       (gray),
      .o_binary     (binary),
      .o_bin_valid  (bin_valid),
      .o_wrap       (wrap),
      .o_wrap_count (wrap_count),
      .o_step_err   (step_err),
      .o_error      (error),
      .o_err_count  (err_count)
   );

   always #5 clk = ~clk;

   function automatic int genc(input int b);
      return b ^ (b >> 1);
   endfunction

   // Inverse by table search over the forward Gray map.
   function automatic int gdec(input int g);
      for (int i = 0; i < N; i++) begin
         if (genc(i) == g) return i;
      end
      return -1;
   endfunction

   function automatic void model_reset();
      m_have = 0; m_ref = 0; m_bin = 0; m_bv = 0; m_wrap = 0;
      m_wc = 0; m_se = 0; m_err = 0; m_ec = 0;
   endfunction

   function automatic void model_step(input bit c, input bit v, input int g);
      int d;
      m_bv = 0; m_wrap = 0; m_se = 0;
      if (c) begin
         m_have = 0; m_err = 0; m_ec = 0; m_wc = 0;
      end else if (v) begin
         d = gdec(g);
         m_bv = 1;
         if (m_have != 0) begin
            if (d == m_ref) begin
               m_se = 0;
            end else if (d == (m_ref + 1) % N) begin
               if (d == 0) begin
                  m_wrap = 1;
                  m_wc = (m_wc + 1) % (1 << WCW);
               end
            end else begin
               m_se = 1;
               m_err = 1;
               if (m_ec < (1 << ECW) - 1) m_ec++;
            end
         end
         m_ref = d; m_have = 1; m_bin = d;
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      n_tests++;
      assert (obs === 32'(exp)) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ctx);
      chk({ctx, ".binary"},     32'(binary),     m_bin);
      chk({ctx, ".bin_valid"},  32'(bin_valid),  m_bv);
      chk({ctx, ".wrap"},       32'(wrap),       m_wrap);
      chk({ctx, ".wrap_count"}, 32'(wrap_count), m_wc);
      chk({ctx, ".step_err"},   32'(step_err),   m_se);
      chk({ctx, ".error"},      32'(error),      m_err);
      chk({ctx, ".err_count"},  32'(err_count),  m_ec);
   endtask

   task automatic step(input string ctx, input bit c, input bit v, input int g);
      clr  = c;
      vld  = v;
      gray = W'(g);
      @(posedge clk);
      model_step(c, v, g);
      #1;
      $display("[TB] %s t=%0t clr=%0b vld=%0b gray=%b -> bin=%0d bv=%0b wrap=%0b wc=%0d se=%0b err=%0b ec=%0d",
               ctx, $time, c, v, W'(g), binary, bin_valid, wrap, wrap_count, step_err, error, err_count);
      check_all(ctx);
   endtask

   // Called at edge+1: asserts reset while clk is high, checks outputs before the next edge.
   task automatic async_reset(input string ctx);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      $display("[TB] %s t=%0t async reset -> bin=%0d err=%0b ec=%0d wc=%0d",
               ctx, $time, binary, error, err_count, wrap_count);
      check_all({ctx, ".rst"});
      #3;
      rst = 1'b0;
   endtask

   initial begin
      int pc;
      int r;
      int g;
      rst = 1'b1; clr = 1'b0; vld = 1'b0; gray = '0;
      model_reset();
      #12;
      check_all("por");
      rst = 1'b0;

      // full cycle with one wrap
      for (int b = 0; b < N; b++) step("full", 1'b0, 1'b1, genc(b));
      step("full", 1'b0, 1'b1, 0);
      chk("full.wrap_last", 32'(wrap), 1);
      chk("full.wrap_count_const", 32'(wrap_count), 1);
      async_reset("full");

      // skipped code, then resync
      step("skip", 1'b0, 1'b1, 0);
      step("skip", 1'b0, 1'b1, 1);
      step("skip", 1'b0, 1'b1, 2);
      chk("skip.bin_const", 32'(binary), 3);
      chk("skip.ec_const", 32'(err_count), 1);
      step("skip", 1'b0, 1'b1, 6);
      chk("skip.resync_se", 32'(step_err), 0);
      chk("skip.sticky", 32'(error), 1);
      async_reset("skip");

      // hold and stall
      for (int i = 0; i < 3; i++) step("hold", 1'b0, 1'b1, 3);
      for (int i = 0; i < 4; i++) step("hold", 1'b0, 1'b0, 5);
      step("hold", 1'b0, 1'b1, 2);
      chk("hold.bin_const", 32'(binary), 3);
      async_reset("hold");

      // first sample unchecked
      step("first", 1'b0, 1'b1, 5);
      step("first", 1'b0, 1'b1, 4);
      chk("first.bin_const", 32'(binary), 7);
      step("first", 1'b0, 1'b1, 0);
      chk("first.wrap_const", 32'(wrap), 1);
      async_reset("first");

      // clear priority from FAULT with two errors
      step("clear", 1'b0, 1'b1, 0);
      step("clear", 1'b0, 1'b1, 2);
      step("clear", 1'b0, 1'b1, 5);
      chk("clear.ec2_const", 32'(err_count), 2);
      step("clear", 1'b1, 1'b1, 7);
      chk("clear.bin_hold_const", 32'(binary), 6);
      chk("clear.bv_const", 32'(bin_valid), 0);
      step("clear", 1'b0, 1'b1, 6);
      chk("clear.unchecked_se", 32'(step_err), 0);
      async_reset("clear");

      // producer counter with random enable and two mid-stream resets
      pc = $urandom_range(0, N - 1);
      for (int i = 0; i < 40; i++) begin
         if (i == 13 || i == 27) async_reset("ctr");
         if ($urandom_range(0, 3) != 0) pc = (pc + 1) % N;
         step("ctr", 1'b0, 1'b1, genc(pc));
      end
      chk("ctr.no_error", 32'(error), 0);
      async_reset("ctr");

      // wrap counter rollover: 257 wraps
      for (int i = 0; i < 2060; i++) step("roll", 1'b0, 1'b1, genc(i % N));
      chk("roll.wc_const", 32'(wrap_count), 1);

      // randomized mix: legal, hold, random codes, stalls, clears
      pc = 0;
      for (int i = 0; i < 1500; i++) begin
         r = $urandom_range(0, 99);
         if (r < 70)      pc = (pc + 1) % N;
         else if (r < 85) pc = pc;
         else             pc = $urandom_range(0, N - 1);
         g = genc(pc);
         r = $urandom_range(0, 99);
         step("rand", (r < 2), (r < 87), g);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
